// File: rtl/xdma_frame_pkg.sv
// Shared frame-format definitions for the XDMA patterned-traffic generator and checker.
// Both ends include this package so header offsets, LFSR and payload pattern stay identical.
package xdma_frame_pkg;

  localparam int FRAME_HDR_BYTES = 8;
  localparam int HDR_SEQ_OFFSET  = 0;
  localparam int HDR_LEN_OFFSET  = 4;
  localparam int HDR_RSVD_OFFSET = 6;
  localparam int BEAT_BYTES      = 64;

  // Fibonacci taps 16,14,13,11 expressed as a mask over the shift-right register
  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

  typedef enum logic {
    ST_HEAD,
    ST_BODY
  } frame_state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return {^(state & LFSR_TAP_MASK), state[15:1]};
  endfunction

  function automatic logic [7:0] pattern_byte(input logic [7:0] seed, input logic [15:0] offset);
    return seed + offset[7:0];
  endfunction

  function automatic logic [6:0] keep_popcount(input logic [63:0] keep);
    logic [6:0] count;
    count = '0;
    for (int i = 0; i < 64; i++) begin
      count = count + 7'(keep[i]);
    end
    return count;
  endfunction

  // Nonzero and packed from lane 0 upward: keep+1 is a power of two
  function automatic logic keep_contiguous(input logic [63:0] keep);
    return (keep != 64'd0) && ((keep & (keep + 64'd1)) == 64'd0);
  endfunction

endpackage

// File: rtl/xdma_beat_pattern_check.sv
// Per-beat payload compare: flags any kept byte past the header that breaks the seq pattern.
module xdma_beat_pattern_check
  import xdma_frame_pkg::*;
#(
  parameter int TDATA_WIDTH = 512,
  parameter int TKEEP_WIDTH = 64
) (
  input  logic [TDATA_WIDTH-1:0] tdata,
  input  logic [TKEEP_WIDTH-1:0] tkeep,
  input  logic [15:0]            beat_offset,
  input  logic [7:0]             seed,
  output logic                   mismatch
);

  always_comb begin
    mismatch = 1'b0;
    for (int lane = 0; lane < TKEEP_WIDTH; lane++) begin
      if (tkeep[lane] &&
          ((beat_offset + 16'(lane)) >= 16'(FRAME_HDR_BYTES)) &&
          (tdata[lane*8 +: 8] != pattern_byte(seed, beat_offset + 16'(lane)))) begin
        mismatch = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xdma_axis_frame_checker.sv
// RX-side checker for patterned XDMA AXI-Stream frames: validates header, sequence, length,
// tkeep shape and payload, reports per-frame results and saturating statistics.
module xdma_axis_frame_checker
  import xdma_frame_pkg::*;
#(
  parameter int XDMA_AXIS_TDATA_WIDTH = 512,
  parameter int XDMA_AXIS_TKEEP_WIDTH = 64,
  parameter int XDMA_AXIS_TUSER_WIDTH = 1,
  parameter int MAX_FRAME_BYTES       = 9000,
  parameter int CNT_WIDTH             = 32
) (
  input  logic                             udp_clk,
  input  logic                             udp_reset,
  input  logic                             xdma_rx_axis_tvalid,
  output logic                             xdma_rx_axis_tready,
  input  logic                             xdma_rx_axis_tlast,
  input  logic [XDMA_AXIS_TDATA_WIDTH-1:0] xdma_rx_axis_tdata,
  input  logic [XDMA_AXIS_TKEEP_WIDTH-1:0] xdma_rx_axis_tkeep,
  input  logic [XDMA_AXIS_TUSER_WIDTH-1:0] xdma_rx_axis_tuser,
  input  logic                             backpressure_en,
  output logic                             frame_done,
  output logic                             frame_ok,
  output logic                             err_seq,
  output logic                             err_len,
  output logic                             err_keep,
  output logic                             err_data,
  output logic [CNT_WIDTH-1:0]             frames_ok_cnt,
  output logic [CNT_WIDTH-1:0]             frames_err_cnt,
  output logic [CNT_WIDTH-1:0]             bytes_cnt
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_BYTES);
  localparam logic [15:0] HDR_LEN = 16'(FRAME_HDR_BYTES);

  frame_state_t state_q, state_d;
  logic           udp_reset_q;
  logic [15:0]    lfsr_q;
  logic [31:0]    seq_q, exp_seq_q;
  logic [15:0]    len_q, offset_q, count_q;
  logic           acc_keep_q, acc_len_q, acc_data_q;

  logic           accept, first_beat;
  logic [31:0]    beat_seq;
  logic [15:0]    beat_len, beat_offset, beat_bytes, count_next, offset_next;
  logic [16:0]    count_sum, offset_sum;
  logic [CNT_WIDTH:0] bytes_sum;
  logic           beat_keep_bad, beat_data_bad;
  logic           frame_keep_bad, frame_data_bad, run_len_bad, frame_len_bad, frame_seq_bad, frame_bad;
  logic           unused_tuser;

  assign unused_tuser = ^xdma_rx_axis_tuser;

  assign xdma_rx_axis_tready = ~udp_reset & ~udp_reset_q & (~backpressure_en | lfsr_q[0]);
  assign accept              = xdma_rx_axis_tvalid & xdma_rx_axis_tready;
  assign first_beat          = (state_q == ST_HEAD);

  // Header fields come straight off the bus on the first beat, from the latches afterwards
  assign beat_seq    = first_beat ? xdma_rx_axis_tdata[HDR_SEQ_OFFSET*8 +: 32] : seq_q;
  assign beat_len    = first_beat ? xdma_rx_axis_tdata[HDR_LEN_OFFSET*8 +: 16] : len_q;
  assign beat_offset = first_beat ? 16'd0 : offset_q;
  assign beat_bytes  = 16'(keep_popcount(xdma_rx_axis_tkeep));

  assign count_sum   = {1'b0, (first_beat ? 16'd0 : count_q)} + {1'b0, beat_bytes};
  assign count_next  = count_sum[16] ? 16'hFFFF : count_sum[15:0];
  assign offset_sum  = {1'b0, beat_offset} + 17'(BEAT_BYTES);
  assign offset_next = offset_sum[16] ? 16'hFFFF : offset_sum[15:0];
  assign bytes_sum   = {1'b0, bytes_cnt} + {{(CNT_WIDTH+1-16){1'b0}}, beat_bytes};

  assign beat_keep_bad = xdma_rx_axis_tlast ? ~keep_contiguous(xdma_rx_axis_tkeep)
                                            : (xdma_rx_axis_tkeep != '1);

  xdma_beat_pattern_check #(
    .TDATA_WIDTH(XDMA_AXIS_TDATA_WIDTH),
    .TKEEP_WIDTH(XDMA_AXIS_TKEEP_WIDTH)
  ) u_pattern_check (
    .tdata      (xdma_rx_axis_tdata),
    .tkeep      (xdma_rx_axis_tkeep),
    .beat_offset(beat_offset),
    .seed       (beat_seq[7:0]),
    .mismatch   (beat_data_bad)
  );

  // run_len_bad can be decided mid-frame; the equality and range terms only at tlast
  assign frame_keep_bad = (~first_beat & acc_keep_q) | beat_keep_bad;
  assign frame_data_bad = (~first_beat & acc_data_q) | beat_data_bad;
  assign run_len_bad    = (~first_beat & acc_len_q) | (first_beat & (beat_bytes < HDR_LEN)) |
                          (count_next > MAX_LEN);
  assign frame_len_bad  = run_len_bad | (count_next != beat_len) | (beat_len < HDR_LEN) |
                          (beat_len > MAX_LEN);
  assign frame_seq_bad  = (beat_seq != exp_seq_q);
  assign frame_bad      = frame_keep_bad | frame_data_bad | frame_len_bad | frame_seq_bad;

  always_ff @(posedge udp_clk) begin
    if (udp_reset) state_q <= ST_HEAD;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) state_d = xdma_rx_axis_tlast ? ST_HEAD : ST_BODY;
  end

  always_ff @(posedge udp_clk) begin
    if (udp_reset) begin
      udp_reset_q    <= 1'b1;
      lfsr_q         <= LFSR_SEED;
      seq_q          <= '0;
      exp_seq_q      <= '0;
      len_q          <= '0;
      offset_q       <= '0;
      count_q        <= '0;
      acc_keep_q     <= 1'b0;
      acc_len_q      <= 1'b0;
      acc_data_q     <= 1'b0;
      frame_done     <= 1'b0;
      frame_ok       <= 1'b0;
      err_seq        <= 1'b0;
      err_len        <= 1'b0;
      err_keep       <= 1'b0;
      err_data       <= 1'b0;
      frames_ok_cnt  <= '0;
      frames_err_cnt <= '0;
      bytes_cnt      <= '0;
    end else begin
      udp_reset_q <= 1'b0;
      lfsr_q      <= lfsr_next(lfsr_q);
      frame_done  <= 1'b0;
      if (accept) begin
        bytes_cnt <= bytes_sum[CNT_WIDTH] ? '1 : bytes_sum[CNT_WIDTH-1:0];
        seq_q     <= beat_seq;
        len_q     <= beat_len;
        offset_q  <= offset_next;
        count_q   <= count_next;
        acc_keep_q <= frame_keep_bad;
        acc_len_q  <= run_len_bad;
        acc_data_q <= frame_data_bad;
        if (xdma_rx_axis_tlast) begin
          frame_done <= 1'b1;
          frame_ok   <= ~frame_bad;
          err_seq    <= err_seq  | frame_seq_bad;
          err_len    <= err_len  | frame_len_bad;
          err_keep   <= err_keep | frame_keep_bad;
          err_data   <= err_data | frame_data_bad;
          exp_seq_q  <= beat_seq + 32'd1;
          if (frame_bad) begin
            if (frames_err_cnt != '1) frames_err_cnt <= frames_err_cnt + CNT_WIDTH'(1);
          end else begin
            if (frames_ok_cnt != '1) frames_ok_cnt <= frames_ok_cnt + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

endmodule
